io_write_arbiter: RTL and testbench

Shares the single write path of the I/O output register bank (three 32-bit output ports) between two requesters. Requester 0 is the CPU memory-stage store path. Requester 1 is the debug/host loader. The block arbitrates round-robin, checks that the address hits a port, and drives the bank's addr/datain/write_io_enable with a registered one-cycle write strobe. Each requester gets a req/ack handshake.

---
 rtl/io_write_arbiter_pkg.sv | 8 +
 rtl/io_port_decode.sv | 15 +
 rtl/io_write_arbiter.sv | 82 ++++++++
 tb/tb_io_write_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/io_write_arbiter_pkg.sv
// io_write_arbiter_pkg: I/O output port map constants and write-arbiter state encoding
package io_write_arbiter_pkg;
  localparam logic [5:0] IO_PORT_BASE = 6'b100000;
  localparam int IO_NUM_PORTS = 3;
  localparam int IO_FLD_HI = 7;
  localparam int IO_FLD_LO = 2;
  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} arb_state_e;
endpackage

// File: rtl/io_port_decode.sv
// io_port_decode: maps the addr[7:2] word field to an output-port hit flag and index
module io_port_decode
  import io_write_arbiter_pkg::*;
(
  input  logic [IO_FLD_HI-IO_FLD_LO:0] fld,
  output logic                         hit,
  output logic [1:0]                   idx
);
  logic [5:0] off;
  always_comb begin
    off = fld - IO_PORT_BASE;
    hit = off < 6'(IO_NUM_PORTS);
    idx = off[1:0];
  end
endmodule

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin sharing of the output bank write path between CPU and loader
module io_write_arbiter
  import io_write_arbiter_pkg::*;
(
  input  logic        io_clk,
  input  logic        clr,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] data0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] data1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] io_addr,
  output logic [31:0] io_datain,
  output logic        io_write_enable
);
  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [31:0] sel_addr;
  logic        g0, g1, hit;
  logic [1:0]  idx;
  // grants only from IDLE; on a tie the requester that did not win last time goes first
  always_comb begin
    g0 = state_q == IDLE && req0 && (!req1 || last_q);
    g1 = state_q == IDLE && req1 && (!req0 || !last_q);
    sel_addr = g1 ? addr1 : addr0;
  end
  io_port_decode u_dec (
    .fld(sel_addr[IO_FLD_HI:IO_FLD_LO]),
    .hit(hit),
    .idx(idx)
  );
  always_comb begin
    state_d = (g0 || g1) ? WRITE : IDLE;
    last_d = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
    ack0_d = g0;
    ack1_d = g1;
    we_d = (g0 || g1) && hit && idx < 2'(IO_NUM_PORTS);
    err0_d = g0 && !we_d;
    err1_d = g1 && !we_d;
    addr_d = (g0 || g1) ? sel_addr : addr_q;
    data_d = g1 ? data1 : g0 ? data0 : data_q;
  end
  always_ff @(posedge io_clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign err0 = err0_q;
  assign err1 = err1_q;
  assign io_write_enable = we_q;
  assign io_addr = addr_q;
  assign io_datain = data_q;
endmodule

// File: tb/tb_io_write_arbiter.sv
// tb_io_write_arbiter: directed and randomized checks of io_write_arbiter against a behavioural model
module tb_io_write_arbiter;
  logic        io_clk = 1'b0;
  logic        clr, req0, req1;
  logic [31:0] addr0, data0, addr1, data1;
  logic        ack0, err0, ack1, err1, io_write_enable;
  logic [31:0] io_addr, io_datain;
  int n_cmp = 0, n_bad = 0;

  always #5 io_clk = ~io_clk;

  io_write_arbiter dut (
    .io_clk(io_clk), .clr(clr),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1), .err1(err1),
    .io_addr(io_addr), .io_datain(io_datain), .io_write_enable(io_write_enable)
  );

  logic [31:0] bank_act[3], bank_exp[3], snap[3];
  bit          m_busy, m_last, m_pend;
  int          m_pidx, s_act;
  logic [31:0] m_pdata;
  logic        e_ack0, e_ack1, e_err0, e_err1, e_we;
  logic [31:0] e_addr, e_data;
  int          order[$];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int slot(logic [31:0] a);
    return int'(a[7:2]) - 32;
  endfunction

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    logic [5:0]  f;
    r = $urandom;
    f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(32 + $urandom_range(0, 3));
    return {r[31:8], f, r[1:0]};
  endfunction

  task automatic mreset();
    m_busy = 0; m_last = 1; m_pend = 0;
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_we = 0;
    e_addr = 0; e_data = 0;
  endtask

  // one bus edge of the reference: a grant cycle is always followed by a dead cycle
  task automatic model_step();
    bit w, hit;
    if (m_pend) begin bank_exp[m_pidx] = m_pdata; m_pend = 0; end
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_we = 0;
    if (!m_busy && (req0 || req1)) begin
      w = (req0 && req1) ? !m_last : req1;
      e_addr = w ? addr1 : addr0;
      e_data = w ? data1 : data0;
      hit = slot(e_addr) >= 0 && slot(e_addr) < 3;
      if (w) begin e_ack1 = 1; e_err1 = !hit; end
      else begin e_ack0 = 1; e_err0 = !hit; end
      e_we = hit;
      if (hit) begin m_pend = 1; m_pidx = slot(e_addr); m_pdata = e_data; end
      m_last = w;
      m_busy = 1;
    end else m_busy = 0;
  endtask

  always @(posedge clr) mreset();

  always @(posedge io_clk) begin
    if (io_write_enable) begin
      s_act = slot(io_addr);
      if (s_act >= 0 && s_act < 3) bank_act[s_act] = io_datain;
    end
  end

  always @(posedge io_clk) begin
    #1;
    if (!clr) begin
      model_step();
      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("err0", err0, e_err0);
      chk("err1", err1, e_err1);
      chk("we", io_write_enable, e_we);
      chk("io_addr", io_addr, e_addr);
      chk("io_datain", io_datain, e_data);
      chk("ack_excl", ack0 & ack1, 0);
    end
  end

  task automatic step();
    @(posedge io_clk);
    #2;
  endtask

  initial begin
    clr = 1; req0 = 0; req1 = 0; addr0 = 0; data0 = 0; addr1 = 0; data1 = 0;
    for (int i = 0; i < 3; i++) begin bank_act[i] = 0; bank_exp[i] = 0; end
    mreset();
    step();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_err0", err0, 0);
    chk("rst_err1", err1, 0);
    chk("rst_we", io_write_enable, 0);
    chk("rst_addr", io_addr, 0);
    chk("rst_data", io_datain, 0);
    clr = 0;
    repeat (10) begin step(); chk("idle_we", io_write_enable, 0); end
    req0 = 1; addr0 = 32'h80; data0 = 32'hDEADBEEF;
    step();
    chk("sw_we", io_write_enable, 1);
    chk("sw_addr", io_addr, 32'h80);
    chk("sw_data", io_datain, 32'hDEADBEEF);
    chk("sw_ack0", ack0, 1);
    chk("sw_err0", err0, 0);
    req0 = 0;
    step();
    chk("sw_port0", bank_act[0], 32'hDEADBEEF);
    #1 clr = 1;
    #1 chk("clr_addr", io_addr, 0);
    chk("clr_data", io_datain, 0);
    step();
    clr = 0;
    req0 = 1; addr0 = 32'h84; data0 = 32'h11;
    req1 = 1; addr1 = 32'h88; data1 = 32'h22;
    step();
    chk("tie_ack0", ack0, 1);
    chk("tie_ack1_first", ack1, 0);
    req0 = 0;
    step();
    chk("tie_gap", ack1, 0);
    step();
    chk("tie_ack1", ack1, 1);
    req1 = 0;
    step();
    chk("tie_port1", bank_act[1], 32'h11);
    chk("tie_port2", bank_act[2], 32'h22);
    req0 = 1; req1 = 1; addr0 = 32'h80; addr1 = 32'h84;
    repeat (16) begin
      step();
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
      if (ack0) data0 = $urandom;
      if (ack1) data1 = $urandom;
      req0 = !ack0;
      req1 = !ack1;
    end
    req0 = 0; req1 = 0;
    chk("fair_cnt", order.size(), 8);
    foreach (order[i]) chk("fair_seq", order[i], i % 2);
    step();
    snap = bank_act;
    req1 = 1; addr1 = 32'h8C; data1 = 32'h55;
    step();
    chk("bad_ack1", ack1, 1);
    chk("bad_err1", err1, 1);
    chk("bad_we", io_write_enable, 0);
    req1 = 0;
    step();
    for (int i = 0; i < 3; i++) chk("bad_port", bank_act[i], snap[i]);
    snap = bank_act;
    req0 = 1; addr0 = 32'h80; data0 = 32'hCAFEF00D;
    step();
    chk("mw_we_pre", io_write_enable, 1);
    #1 clr = 1;
    #1 chk("mw_we_clr", io_write_enable, 0);
    chk("mw_ack_clr", ack0, 0);
    req0 = 0;
    step();
    clr = 0;
    step();
    chk("mw_port0", bank_act[0], snap[0]);
    req1 = 1; addr1 = 32'h88; data1 = 32'h77;
    step();
    chk("mw_idle_ack1", ack1, 1);
    req1 = 0;
    step();
    repeat (600) begin
      step();
      if (ack0) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1; addr0 = raddr(); data0 = $urandom; end
      else if (req0 && $urandom_range(0, 15) == 0) req0 = 0;
      if (ack1) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1; addr1 = raddr(); data1 = $urandom; end
      else if (req1 && $urandom_range(0, 15) == 0) req1 = 0;
    end
    req0 = 0; req1 = 0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) chk("bank_final", bank_act[i], bank_exp[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
